// File: rtl/seg7_scan_if.sv
// Bundle of the scan driver's strobe, data-capture and display signals.
// The bench drives it through the master modport; the driver uses the slave modport.
interface seg7_scan_if;
  logic        div_clk;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        data_valid;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output div_clk, data, dp_mask, data_valid,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  div_clk, data, dp_mask, data_valid,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment scanner, one digit per divider rising edge.
// Define SEG7_LEAD_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module seg7_scan #(
  parameter int DIGITS = 8
) (
  input  logic CLK,
  input  logic rst_n,
  seg7_scan_if.slave bus
);

  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  logic        r_divQ;
  logic [2:0]  r_idx;
  logic        r_active;
  logic        r_frameDone;
  logic [31:0] r_shadow;
  logic [7:0]  r_dpShadow;
  logic [31:0] r_pending;
  logic [7:0]  r_pendDp;
  logic        r_pendFlag;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_rise;
  logic        w_wrap;
  logic [3:0]  w_nibble;
  logic [6:0]  w_glyph;
  logic [6:0]  w_segNext;

  assign w_rise = bus.div_clk & ~r_divQ;
  assign w_wrap = w_rise && (r_idx == LAST);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_divQ      <= 1'b0;
      r_idx       <= LAST;
      r_active    <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_divQ      <= bus.div_clk;
      r_frameDone <= w_wrap;
      if (w_rise) begin
        r_idx    <= (r_idx == LAST) ? 3'd0 : r_idx + 3'd1;
        r_active <= 1'b1;
      end
    end
  end

  // Shadow only moves at a wrap so a frame never mixes old and new digits;
  // a capture on the wrap edge itself bypasses and retires the pending copy.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_dpShadow <= '0;
      r_pending  <= '0;
      r_pendDp   <= '0;
      r_pendFlag <= 1'b0;
    end else begin
      if (bus.data_valid) begin
        r_pending <= bus.data;
        r_pendDp  <= bus.dp_mask;
      end
      if (w_wrap && bus.data_valid) begin
        r_shadow   <= bus.data;
        r_dpShadow <= bus.dp_mask;
        r_pendFlag <= 1'b0;
      end else if (w_wrap && r_pendFlag) begin
        r_shadow   <= r_pending;
        r_dpShadow <= r_pendDp;
        r_pendFlag <= 1'b0;
      end else if (bus.data_valid) begin
        r_pendFlag <= 1'b1;
      end
    end
  end

  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nibble)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

`ifdef SEG7_LEAD_BLANK_EN
  logic [7:0] w_blank;
  logic       w_allZero;

  // Walk down from the top scanned digit; a digit blanks while everything above it is zero.
  always_comb begin
    w_allZero = 1'b1;
    w_blank   = '0;
    for (int i = 7; i >= 1; i--) begin
      if (i < DIGITS) begin
        w_allZero = w_allZero & (r_shadow[4*i +: 4] == 4'h0);
      end
      w_blank[i] = w_allZero;
    end
  end

  assign w_segNext = w_blank[r_idx] ? 7'h7F : w_glyph;
`else
  assign w_segNext = w_glyph;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (!r_active) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_segNext;
      r_dp  <= ~r_dpShadow[r_idx];
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: table-driven frame scans plus hand-written corner sequences.
// Expected glyphs follow SEG7_LEAD_BLANK_EN when it is defined for the build.
module tb_seg7_scan;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } vec_t;

`ifdef SEG7_LEAD_BLANK_EN
  localparam logic [6:0] ZB = 7'h7F;
`else
  localparam logic [6:0] ZB = 7'h40;
`endif

  logic CLK;
  logic rst_n;
  int   vectors;
  int   errors;

  seg7_scan_if bus ();

  seg7_scan #(.DIGITS(8)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expAn, input logic [6:0] expSeg,
                             input logic expDp, input logic expFd, input logic actFd);
    vectors++;
    if ({bus.an, bus.seg, bus.dp, actFd} !== {expAn, expSeg, expDp, expFd}) begin
      errors++;
      $display("[TB] FAIL %s: got an=%h seg=%h dp=%b fd=%b, expected an=%h seg=%h dp=%b fd=%b",
               name, bus.an, bus.seg, bus.dp, actFd, expAn, expSeg, expDp, expFd);
    end
  endtask

  task automatic checkBlank(input string name);
    checkOutput(name, 8'hFF, 7'h7F, 1'b1, 1'b0, bus.frame_done);
  endtask

  // One div_clk rise (optionally with data_valid on the same edge), then let the outputs settle.
  task automatic applyStimulus(input logic withValid, output logic fdSeen);
    bus.div_clk    = 1'b1;
    bus.data_valid = withValid;
    step();
    fdSeen         = bus.frame_done & ~withValid | bus.frame_done;
    bus.div_clk    = 1'b0;
    bus.data_valid = 1'b0;
    step();
    fdSeen = fdSeen & ~bus.frame_done;
  endtask

  task automatic scanRise(input string name, input logic [7:0] expAn, input logic [6:0] expSeg,
                          input logic expDp, input logic expFd);
    logic fd;
    applyStimulus(1'b0, fd);
    checkOutput(name, expAn, expSeg, expDp, expFd, fd);
  endtask

  task automatic loadData(input logic [31:0] d, input logic [7:0] m);
    bus.data       = d;
    bus.dp_mask    = m;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
  endtask

  initial begin
    vec_t frameA[8];
    vec_t frameB[8];
    logic fd;
    logic [7:0] oneHot;

    frameA[0] = '{8'hFE, 7'h00, 1'b0, 1'b1};
    frameA[1] = '{8'hFD, 7'h78, 1'b1, 1'b0};
    frameA[2] = '{8'hFB, 7'h02, 1'b1, 1'b0};
    frameA[3] = '{8'hF7, 7'h12, 1'b1, 1'b0};
    frameA[4] = '{8'hEF, 7'h19, 1'b1, 1'b0};
    frameA[5] = '{8'hDF, 7'h30, 1'b1, 1'b0};
    frameA[6] = '{8'hBF, 7'h24, 1'b1, 1'b0};
    frameA[7] = '{8'h7F, 7'h79, 1'b1, 1'b0};

    frameB[0] = '{8'hFE, 7'h40, 1'b0, 1'b1};
    frameB[1] = '{8'hFD, 7'h40, 1'b1, 1'b0};
    frameB[2] = '{8'hFB, 7'h40, 1'b0, 1'b0};
    frameB[3] = '{8'hF7, 7'h10, 1'b1, 1'b0};
    frameB[4] = '{8'hEF, 7'h03, 1'b1, 1'b0};
    frameB[5] = '{8'hDF, 7'h46, 1'b0, 1'b0};
    frameB[6] = '{8'hBF, 7'h21, 1'b1, 1'b0};
    frameB[7] = '{8'h7F, 7'h06, 1'b0, 1'b0};

    vectors        = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.div_clk    = 1'b0;
    bus.data       = '0;
    bus.dp_mask    = '0;
    bus.data_valid = 1'b0;

    step();
    checkBlank("reset idle");
    for (int i = 0; i < 3; i++) begin
      bus.div_clk = ~bus.div_clk;
      step();
      checkBlank("reset with div_clk toggling");
    end
    bus.div_clk = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    checkBlank("post reset release");

    loadData(32'h12345678, 8'h01);
    step();
    checkBlank("captured but no rise");

    for (int i = 0; i < 8; i++) begin
      scanRise($sformatf("frame A digit %0d", i), frameA[i].an, frameA[i].seg, frameA[i].dp, frameA[i].fd);
    end
    scanRise("frame A rewrap", 8'hFE, 7'h00, 1'b0, 1'b1);

    bus.div_clk = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checkOutput("level hold high", 8'hFD, 7'h78, 1'b1, 1'b0, bus.frame_done);
    bus.div_clk = 1'b0;
    step();
    step();
    checkOutput("level hold released", 8'hFD, 7'h78, 1'b1, 1'b0, bus.frame_done);

    scanRise("advance digit 2", 8'hFB, 7'h02, 1'b1, 1'b0);
    scanRise("advance digit 3", 8'hF7, 7'h12, 1'b1, 1'b0);

    loadData(32'hFFFFFFFF, 8'h00);
    for (int i = 4; i < 8; i++) begin
      scanRise($sformatf("tear-free old digit %0d", i), frameA[i].an, frameA[i].seg, frameA[i].dp, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      oneHot = 8'b1 << i;
      scanRise($sformatf("new frame F digit %0d", i), ~oneHot, 7'h0E, 1'b1, (i == 0));
    end

    loadData(32'h12345678, 8'hFF);
    bus.data    = 32'hAAAAAAAA;
    bus.dp_mask = 8'h00;
    applyStimulus(1'b1, fd);
    checkOutput("valid on wrap edge", 8'hFE, 7'h08, 1'b1, 1'b1, fd);
    for (int i = 1; i < 8; i++) begin
      oneHot = 8'b1 << i;
      scanRise($sformatf("frame A5 digit %0d", i), ~oneHot, 7'h08, 1'b1, 1'b0);
    end
    scanRise("stale pending discarded", 8'hFE, 7'h08, 1'b1, 1'b1);

    loadData(32'h000000A5, 8'h00);
    for (int i = 1; i < 8; i++) begin
      oneHot = 8'b1 << i;
      scanRise($sformatf("pre-blank old digit %0d", i), ~oneHot, 7'h08, 1'b1, 1'b0);
    end
    scanRise("A5 digit 0", 8'hFE, 7'h12, 1'b1, 1'b1);
    scanRise("A5 digit 1", 8'hFD, 7'h08, 1'b1, 1'b0);
    for (int i = 2; i < 8; i++) begin
      oneHot = 8'b1 << i;
      scanRise($sformatf("A5 leading digit %0d", i), ~oneHot, ZB, 1'b1, 1'b0);
    end

    loadData(32'h00000000, 8'h00);
    scanRise("zero digit 0", 8'hFE, 7'h40, 1'b1, 1'b1);
    scanRise("zero digit 1", 8'hFD, ZB, 1'b1, 1'b0);
    scanRise("zero digit 2", 8'hFB, ZB, 1'b1, 1'b0);
    scanRise("zero digit 3", 8'hF7, ZB, 1'b1, 1'b0);

    rst_n = 1'b0;
    #2;
    checkBlank("async reset mid-frame");
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    checkBlank("blank after release");
    scanRise("fresh frame digit 0", 8'hFE, 7'h40, 1'b1, 1'b1);

    loadData(32'hEDCB9000, 8'hA5);
    for (int i = 1; i < 8; i++) begin
      oneHot = 8'b1 << i;
      scanRise($sformatf("post-reset digit %0d", i), ~oneHot, ZB, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      scanRise($sformatf("frame B digit %0d", i), frameB[i].an, frameB[i].seg, frameB[i].dp, frameB[i].fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
